fft_stream_ctrl: RTL and testbench
==================================

Name: fft_stream_ctrl

Overview:
Frame sequencer between the audio sample stream and the Avalon-ST FFT core.
- Cuts the continuous sample stream into FFT_PTS-point frames and drives sink_sop/sink_eop.
- Selects forward or inverse transform per frame and applies FFT backpressure to the audio source.
- Accepts the core's output frame, checks its length and error code, and pulses completion.

Parameters:
FFT_PTS, 256, transform length in points (power of two, 8..4096)
DATA_W, 16, sample width for real and imaginary parts
PTS_W, 9, width of fftpts_in (log2(FFT_PTS)+1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  audio sample valid
in_ready  out  1  audio sample accepted this cycle when in_valid && in_ready
in_data  in  DATA_W  signed audio sample
cfg_inverse  in  1  transform direction for the next frame: 1 = inverse
sink_valid  out  1  to FFT sink
sink_ready  in  1  from FFT sink
sink_sop  out  1  first point of frame
sink_eop  out  1  last point of frame
sink_real  out  DATA_W  equals in_data
sink_imag  out  DATA_W  constant 0
sink_error  out  2  constant 0
fftpts_in  out  PTS_W  constant FFT_PTS
inverse  out  1  latched direction of the frame in flight
source_valid  in  1  FFT output valid
source_ready  out  1  controller accepts FFT output
source_sop  in  1  FFT output start of frame
source_eop  in  1  FFT output end of frame
source_error  in  2  FFT output error code
frame_done  out  1  one-cycle pulse on accepted output eop
err_flag  out  1  sticky error; cleared only by reset

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, counters 0, inverse 0, err_flag 0, frame_done 0, in_ready 0, sink_valid 0, source_ready 0.
- Handshakes:
  - Input handshake: in_valid && in_ready.
  - Sink handshake: sink_valid && sink_ready.
  - Source handshake: source_valid && source_ready.
- Input path is combinational, zero latency:
  - In SEND: sink_valid = in_valid and in_ready = sink_ready. Otherwise both are 0.
  - sink_sop = (in_cnt == 0), sink_eop = (in_cnt == FFT_PTS-1), both qualified by SEND.
- State IDLE:
  - Entered from reset or after frame_done.
  - Moves to SEND on the next cycle. inverse <= cfg_inverse is latched on that transition.
- State SEND:
  - in_cnt increments on each sink handshake.
  - An idle gap (in_valid=0) or backpressure (sink_ready=0) holds in_cnt; sop/eop stay aligned to in_cnt.
  - On the handshake at in_cnt == FFT_PTS-1: in_cnt <= 0, next state WAIT_OUT.
- State WAIT_OUT:
  - source_ready = 1 and in_ready = 0, so only one frame is in flight.
  - out_cnt increments on each source handshake.
  - On a source handshake with source_eop: frame_done pulses next cycle, out_cnt <= 0, state -> IDLE.
- Error checks (err_flag is set, state flow is unaffected):
  - source_sop with out_cnt != 0.
  - source_eop with out_cnt != FFT_PTS-1.
  - out_cnt reaching FFT_PTS-1 without source_eop. out_cnt then wraps to 0 and the frame stays open until eop.
  - source_error != 0 on any source handshake.
- Source input received outside WAIT_OUT is ignored, because source_ready is 0.
- cfg_inverse changes mid-frame have no effect until the next IDLE->SEND transition.
- Reset mid-frame: all state is discarded immediately. Recovering the FFT core is the core's own reset's job.
- Throughput: 1 sample/cycle in SEND. Frame period is at least FFT_PTS + core latency + FFT_PTS + 2 cycles.

Optional Feature:
FFT_OVERLAP_EN
- Defined:
  - WAIT_OUT no longer blocks the input. After the input eop the controller returns to SEND via IDLE while the output is still draining.
  - A 2-entry direction FIFO records inverse per frame. A 2-bit outstanding counter caps in-flight frames at 2.
  - SEND is not entered while 2 frames are outstanding.
  - source_ready = 1 whenever outstanding > 0.
  - frame_done pulses per output eop.
- Undefined: the single-frame behaviour above.

Decomposition:
- Package fft_ctrl_pkg:
  - state enum {IDLE, SEND, WAIT_OUT}.
  - default FFT_PTS, DATA_W, PTS_W constants.
  - error-code constants matching the core's source_error encoding.
- Sub-module fft_pkt_counter, instantiated twice (input and output):
  - Ports: clk, reset_n, inc, clr. Parameter N.
  - Output count; first = (count == 0); last = (count == N-1). Wraps to 0 after N-1.

Test Plan:
- Basic frame:
  - FFT_PTS=8, continuous in_valid, sink_ready=1, cfg_inverse=0.
  - Expect sop at sample 0 and eop at sample 7, inverse=0.
  - A model core returning 8 points gives frame_done one cycle after its eop, err_flag=0.
- Backpressure:
  - sink_ready low for 3 cycles at in_cnt=4, plus an in_valid gap at in_cnt=6.
  - Expect in_ready to follow sink_ready, in_cnt to hold, and exactly 8 handshakes with sop/eop on points 0 and 7.
- Direction latch:
  - cfg_inverse=1 at frame start, toggled to 0 at point 3.
  - Expect inverse=1 for the whole frame and 0 for the next frame.
- Length error:
  - Model core asserts source_eop at output point 5.
  - Expect err_flag=1 (sticky), frame_done pulses, return to IDLE, next frame proceeds normally.
- Core error:
  - source_error=2'b01 on output point 2.
  - Expect err_flag=1 and the frame still completes.
- Reset mid-frame:
  - reset_n low at in_cnt=3 in SEND.
  - Expect all outputs at reset values immediately. After release, the next accepted sample carries sink_sop=1.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer: FSM encoding,
// default geometry and the FFT core's source_error code points.
package fft_ctrl_pkg;

  localparam int DEF_FFT_PTS = 256;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PTS_W   = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_OUT = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_SEND     = SEND;
  localparam logic [1:0] ST_WAIT_OUT = WAIT_OUT;

  // Encoding used by the core on source_error / sink_error.
  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_MISSING_SOP    = 2'b01;
  localparam logic [1:0] ERR_MISSING_EOP    = 2'b10;
  localparam logic [1:0] ERR_UNEXPECTED_EOP = 2'b11;

  function automatic logic is_core_error(input logic [1:0] code);
    return code != ERR_NONE;
  endfunction

endpackage

// File: rtl/fft_pkt_counter.sv
// Modulo-N point counter with first/last flags; wraps to 0 after N-1.
module fft_pkt_counter #(
  parameter int N  = 256,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          first,
  output logic          last
);

  assign first = (count == '0);
  assign last  = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr || (inc && last)) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fft_stream_ctrl.sv
// Frame sequencer between the audio stream and the Avalon-ST FFT core.
// Build option FFT_OVERLAP_EN allows up to two frames in flight.
//
// Handshake rule on every interface (in_*, sink_*, source_*): a beat transfers
// on a cycle where valid && ready; valid never waits on ready, and the
// controller's ready outputs depend only on state and the partner's ready.
module fft_stream_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_PTS = DEF_FFT_PTS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PTS_W   = DEF_PTS_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cfg_inverse,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  output logic [PTS_W-1:0]  fftpts_in,
  output logic              inverse,
  input  logic              source_valid,
  output logic              source_ready,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [1:0]        source_error,
  output logic              frame_done,
  output logic              err_flag,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(FFT_PTS);

  logic [1:0]    state, state_nxt;
  logic          sending, sink_hs, src_hs, in_eop_hs, out_eop_hs, err_set;
  logic          drain_dir;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          in_first, in_last, out_first, out_last;

  assign sending    = (state == ST_SEND);
  assign sink_valid = sending & in_valid;
  assign in_ready   = sending & sink_ready;
  assign sink_sop   = sending & in_first;
  assign sink_eop   = sending & in_last;
  assign sink_real  = in_data;
  assign sink_imag  = '0;
  assign sink_error = ERR_NONE;
  assign fftpts_in  = PTS_W'(FFT_PTS);

  assign sink_hs    = sink_valid & sink_ready;
  assign src_hs     = source_valid & source_ready;
  assign in_eop_hs  = sink_hs & in_last;
  assign out_eop_hs = src_hs & source_eop;

  fft_pkt_counter #(.N(FFT_PTS), .CW(CW)) u_in_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sink_hs),
    .clr     (1'b0),
    .count   (in_cnt),
    .first   (in_first),
    .last    (in_last)
  );

  // The output counter restarts on every eop, even a misplaced one, so the
  // next frame is checked from a clean position.
  fft_pkt_counter #(.N(FFT_PTS), .CW(CW)) u_out_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (src_hs & ~source_eop),
    .clr     (out_eop_hs),
    .count   (out_cnt),
    .first   (out_first),
    .last    (out_last)
  );

  assign err_set = src_hs & ((source_sop & ~out_first) |
                             (source_eop & ~out_last)  |
                             (~source_eop & out_last)  |
                             is_core_error(source_error));

`ifdef FFT_OVERLAP_EN
  logic [1:0] outstanding;
  logic [1:0] dir_fifo;
  logic       dir_wr, dir_rd;

  assign source_ready = (outstanding != 2'd0);
  assign drain_dir    = dir_fifo[dir_rd];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (outstanding != 2'd2) state_nxt = ST_SEND;
      ST_SEND: if (in_eop_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= 2'd0;
      dir_fifo    <= 2'b00;
      dir_wr      <= 1'b0;
      dir_rd      <= 1'b0;
    end else begin
      case ({in_eop_hs, out_eop_hs})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
      if (in_eop_hs) begin
        dir_fifo[dir_wr] <= inverse;
        dir_wr           <= ~dir_wr;
      end
      if (out_eop_hs) dir_rd <= ~dir_rd;
    end
  end
`else
  assign source_ready = (state == ST_WAIT_OUT);
  assign drain_dir    = inverse;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = ST_SEND;
      ST_SEND:     if (in_eop_hs) state_nxt = ST_WAIT_OUT;
      ST_WAIT_OUT: if (out_eop_hs) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      inverse    <= 1'b0;
      frame_done <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= out_eop_hs;
      err_flag   <= err_flag | err_set;
      // Direction is frozen for the whole frame once sending starts.
      if (state == ST_IDLE && state_nxt == ST_SEND) inverse <= cfg_inverse;
    end
  end

  assign state_dbg = {drain_dir, state};

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl with FFT_PTS=8: directed frames,
// a backpressure vector table, error and reset cases, then random traffic.
module tb_fft_stream_ctrl;

  localparam int PTS = 8;
  localparam int DW  = 16;
  localparam int PW  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, cfg_inverse;
  logic [DW-1:0] in_data;
  logic          sink_valid, sink_ready, sink_sop, sink_eop;
  logic [DW-1:0] sink_real, sink_imag;
  logic [1:0]    sink_error;
  logic [PW-1:0] fftpts_in;
  logic          inverse;
  logic          source_valid, source_ready, source_sop, source_eop;
  logic [1:0]    source_error;
  logic          frame_done, err_flag;
  logic [2:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  fft_stream_ctrl #(.FFT_PTS(PTS), .DATA_W(DW), .PTS_W(PW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .cfg_inverse  (cfg_inverse),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .fftpts_in    (fftpts_in),
    .inverse      (inverse),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .frame_done   (frame_done),
    .err_flag     (err_flag),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid     = 1'b0;
    sink_ready   = 1'b0;
    cfg_inverse  = 1'b0;
    in_data      = '0;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_error = 2'b00;
  endtask

  // Ends 1 ns after a rising edge with the DUT in its post-reset idle cycle.
  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered in the idle cycle; sends one full input frame with no stalls.
  task automatic send_frame(input logic inv, input int toggle_at, input logic exp_err);
    cfg_inverse = inv;
    in_valid    = 1'b1;
    sink_ready  = 1'b1;
    #3;
    chk("idle_sink_valid", sink_valid, 0);
    chk("idle_in_ready", in_ready, 0);
    tick();
    for (int k = 0; k < PTS; k++) begin
      in_data = DW'($urandom);
      if (k == toggle_at) cfg_inverse = ~inv;
      #3;
      chk("send_sop", sink_sop, (k == 0));
      chk("send_eop", sink_eop, (k == PTS - 1));
      chk("send_valid", sink_valid, 1);
      chk("send_in_ready", in_ready, 1);
      chk("send_real", sink_real, in_data);
      chk("send_inverse", inverse, inv);
      chk("send_err", err_flag, exp_err);
      if (k == 0) chk("send_no_done", frame_done, 0);
      tick();
    end
    in_valid = 1'b0;
    #3;
    chk("wait_in_ready", in_ready, 0);
    chk("wait_source_ready", source_ready, 1);
    chk("wait_inverse", inverse, inv);
    tick();
  endtask

  // Model core: returns len points back to back; ends in the idle cycle.
  task automatic core_frame(input int len, input int err_pt, input logic [1:0] code,
                            input logic exp_err);
    for (int p = 0; p < len; p++) begin
      source_valid = 1'b1;
      source_sop   = (p == 0);
      source_eop   = (p == len - 1);
      source_error = (p == err_pt) ? code : 2'b00;
      #3;
      chk("core_source_ready", source_ready, 1);
      chk("core_no_done", frame_done, 0);
      tick();
    end
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_error = 2'b00;
    chk("core_frame_done", frame_done, 1);
    chk("core_err_flag", err_flag, exp_err);
    chk("core_back_idle", source_ready, 0);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a one-cycle turnaround, PTS accepted samples, then
  // drain the core's output until its eop.
  bit m_gap, m_drain, m_dir, m_err, m_done;
  int m_acc, m_out;

  task automatic model_init();
    m_gap = 1'b1; m_drain = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_done = 1'b0;
    m_acc = 0;    m_out = 0;
  endtask

  task automatic model_step();
    bit done_nxt;
    int pos;
    done_nxt = m_drain && source_valid && source_eop;
    if (m_gap) begin
      m_gap = 1'b0;
      m_dir = cfg_inverse;
    end else if (!m_drain) begin
      if (in_valid && sink_ready) begin
        m_acc++;
        if (m_acc == PTS) begin
          m_acc   = 0;
          m_drain = 1'b1;
        end
      end
    end else if (source_valid) begin
      pos = m_out % PTS;
      if ((source_sop && pos != 0) || (source_eop && pos != PTS - 1) ||
          (!source_eop && pos == PTS - 1) || source_error != 2'b00)
        m_err = 1'b1;
      if (source_eop) begin
        m_drain = 1'b0;
        m_gap   = 1'b1;
        m_out   = 0;
      end else begin
        m_out++;
      end
    end
    m_done = done_nxt;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic iv, sr;
    logic sv, ir, sop, eop;
  } vec_t;

  vec_t tbl [14];

  // ---------------- test ----------------
  initial begin
    int  core_idx, core_len;
    bit  was_drain, exp_sv;
    logic [7:0] act_v, exp_v;

    // Backpressure frame: stall at point 4 for 3 cycles, gap at point 6.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, with the inputs pushing as hard as they can.
    reset_n = 1'b0;
    clear_inputs();
    in_valid = 1'b1; sink_ready = 1'b1; source_valid = 1'b1; source_eop = 1'b1;
    #3;
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_source_ready", source_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_inverse", inverse, 0);
    chk("rst_sop", sink_sop, 0);
    chk("const_imag", sink_imag, 0);
    chk("const_sink_error", sink_error, 0);
    chk("const_fftpts", fftpts_in, PTS);
    do_reset();

    // Basic frame.
    send_frame(1'b0, -1, 1'b0);
    core_frame(PTS, -1, 2'b00, 1'b0);

    // Backpressure table, entered in the idle cycle.
    begin
      int hs = 0;
      for (int r = 0; r < 14; r++) begin
        in_valid   = tbl[r].iv;
        sink_ready = tbl[r].sr;
        in_data    = DW'(r * 17 + 3);
        #3;
        chk("tbl_sink_valid", sink_valid, tbl[r].sv);
        chk("tbl_in_ready", in_ready, tbl[r].ir);
        chk("tbl_sop", sink_sop, tbl[r].sop);
        chk("tbl_eop", sink_eop, tbl[r].eop);
        if (sink_valid && sink_ready) hs++;
        tick();
      end
      chk("tbl_handshakes", hs, PTS);
      in_valid = 1'b0;
      core_frame(PTS, -1, 2'b00, 1'b0);
    end

    // Direction latch: toggle mid-frame has no effect until the next frame.
    send_frame(1'b1, 3, 1'b0);
    core_frame(PTS, -1, 2'b00, 1'b0);
    send_frame(1'b0, -1, 1'b0);
    core_frame(PTS, -1, 2'b00, 1'b0);

    // Length error: early eop at point 5, sticky flag, next frame normal.
    send_frame(1'b0, -1, 1'b0);
    core_frame(6, -1, 2'b00, 1'b1);
    send_frame(1'b0, -1, 1'b1);
    core_frame(PTS, -1, 2'b00, 1'b1);

    // Core error code on point 2.
    do_reset();
    send_frame(1'b0, -1, 1'b0);
    core_frame(PTS, 2, 2'b01, 1'b1);

    // Reset at in_cnt == 3 with inverse and err_flag both set.
    cfg_inverse = 1'b1; in_valid = 1'b1; sink_ready = 1'b1;
    tick();
    repeat (3) tick();
    chk("pre_rst_inverse", inverse, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_sink_valid", sink_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_inverse", inverse, 0);
    chk("midrst_err_flag", err_flag, 0);
    chk("midrst_sop", sink_sop, 0);
    chk("midrst_frame_done", frame_done, 0);
    #1;
    reset_n = 1'b1;
    send_frame(1'b0, -1, 1'b0);
    core_frame(PTS, -1, 2'b00, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    model_init();
    core_idx = 0;
    core_len = PTS;
    for (int c = 0; c < 3000; c++) begin
      if (c % 397 == 396) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_init();
        core_idx = 0;
        core_len = PTS;
      end
      in_valid    = ($urandom_range(0, 3) != 0);
      sink_ready  = ($urandom_range(0, 3) != 0);
      cfg_inverse = 1'($urandom_range(0, 1));
      in_data     = DW'($urandom);
      if (m_drain) begin
        source_valid = ($urandom_range(0, 3) != 0);
        source_sop   = (core_idx == 0);
        source_eop   = (core_idx == core_len - 1);
        source_error = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else begin
        source_valid = ($urandom_range(0, 7) == 0);
        source_sop   = 1'($urandom_range(0, 1));
        source_eop   = 1'($urandom_range(0, 1));
        source_error = 2'($urandom_range(0, 3));
      end
      #2;
      exp_sv = !m_gap && !m_drain && in_valid;
      exp_v  = {exp_sv, (!m_gap && !m_drain && sink_ready),
                (!m_gap && !m_drain && m_acc == 0), (!m_gap && !m_drain && m_acc == PTS - 1),
                m_drain, m_done, m_err, m_dir};
      act_v  = {sink_valid, in_ready, sink_sop, sink_eop, source_ready, frame_done,
                err_flag, inverse};
      chk("rand_outputs", act_v, exp_v);
      if (exp_sv) chk("rand_real", sink_real, in_data);
      was_drain = m_drain;
      model_step();
      if (was_drain && source_valid) begin
        if (source_eop) begin
          core_idx = 0;
          core_len = ($urandom_range(0, 19) == 0) ? 5 :
                     (($urandom_range(0, 19) == 0) ? 11 : PTS);
        end else begin
          core_idx++;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
